num_to_ascii_stream: RTL and testbench
======================================

// Module: num_to_ascii_stream
// PURPOSE
//  Sequential, parametrised integer-to-ASCII converter: the hardware successor to the
//  string itoa/hextoa/octtoa/bintoa methods. Accepts one WIDTH-bit value per transaction
//  with a run-time radix (bin/oct/dec/hex) and signedness. Emits the textual digits
//  MSB-first as a valid/ready byte stream with an end-of-string marker.
//  Sits between numeric datapaths and text/log formatters (UART, trace, string packers).
// PARAMETERS
//  WIDTH      32   bit width of in_value (2..64)
//  MAX_CHARS  WIDTH+1  localparam: digit stack depth (binary worst case plus sign)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid && in_ready
//  in_value   in   WIDTH  value to convert
//  in_radix   in   2      0=bin 1=oct 2=dec 3=hex
//  in_signed  in   1      treat in_value as two's complement (decimal only)
//  out_valid  out  1      out_char valid
//  out_ready  in   1      sink accepts char when out_valid && out_ready
//  out_char   out  8      ASCII character
//  out_last   out  1      high with final character of the string
//  out_len    out  $clog2(MAX_CHARS+1)  total chars of current string, valid in EMIT
//  busy       out  1      high in CONVERT or EMIT
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_char=0, out_len=0, busy=0.
//  FSM IDLE -> CONVERT on accept; CONVERT -> EMIT when last digit pushed;
//   EMIT -> IDLE on handshake of out_last char. in_ready=1 only in IDLE.
//  Accept: latch radix, neg = in_signed && radix==dec && in_value[WIDTH-1];
//   magnitude = neg ? (~in_value + 1) : in_value, taken as unsigned WIDTH bits
//   (so -2^(WIDTH-1) converts correctly). in_signed ignored for bin/oct/hex.
//  CONVERT: one digit per cycle, LSB digit first, pushed on internal stack:
//   digit = mag mod R, mag <= mag / R (R=2/8/16 by shift, R=10 by constant divide).
//   Stop after the cycle in which updated mag==0; value 0 yields exactly one '0'.
//   No leading zeros, ever. If neg, '-' pushed in the cycle after the last digit.
//   Cycles in CONVERT = N digits (+1 if neg).
//  Digit map: 0-9 -> 8'h30-8'h39, 10-15 -> lowercase 'a'-'f' (8'h61-8'h66).
//  EMIT: out_valid rises the cycle after CONVERT ends; chars popped LIFO (MSB/sign first).
//   out_char/out_last held stable while out_valid && !out_ready.
//   Handshake on last char: out_valid=0 and in_ready=1 next cycle; no bubble inside a string.
//   out_len = chars pushed, constant throughout EMIT.
//  Inputs sampled only at accept; changes to in_* during CONVERT/EMIT have no effect.
//  rst_n low at any time (mid-CONVERT/EMIT): immediate return to reset values, string
//   discarded; no partial char or out_last emitted after release.
//  Stack never overflows: MAX_CHARS covers WIDTH binary digits or decimal digits + sign.
// TESTING
//  hex 32'hDEADBEEF -> 8 CONVERT cycles, stream "deadbeef", out_last on 'f', out_len=8.
//  dec signed -123 -> "-123", out_len=4; same value unsigned -> "4294967173".
//  dec signed 32'h8000_0000 -> "-2147483648" (11 chars); unsigned 32'hFFFFFFFF -> "4294967295".
//  bin 0 -> single '0' (8'h30) with out_last=1; oct 32'o17 -> "17"; bin 5 -> "101".
//  random out_ready stalls on "deadbeef" -> out_char stable while stalled, no drop/duplicate;
//   in_valid held high throughout -> second request accepted only cycle after final handshake.
//  rst_n pulse during EMIT of "4294967295" after 3 chars -> out_valid=0 immediately,
//   in_ready=1 after release, next request (hex 0xA) streams clean "a".

Source files
------------

// File: rtl/num_to_ascii_stream.sv
// num_to_ascii_stream
//   Converts one WIDTH-bit integer per request into its ASCII text in binary,
//   octal, decimal or hexadecimal, and streams the characters MSB-first over
//   a valid/ready byte interface. The final character is flagged with out_last.
//   Digits are produced LSB-first, one per cycle, onto a small stack. The stack
//   is then popped, so the text leaves in reading order: sign first, then the
//   most significant digit.
module num_to_ascii_stream #(
   parameter int WIDTH = 32
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [WIDTH-1:0]                       in_value,
   input  logic [1:0]                             in_radix,
   input  logic                                   in_signed,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [7:0]                             out_char,
   output logic                                   out_last,
   output logic [$clog2(WIDTH+1+1)-1:0]           out_len,
   output logic                                   busy
);

   // Deepest string is WIDTH binary digits. A decimal string plus its sign
   // always fits inside that.
   localparam int MAX_CHARS = WIDTH + 1;
   localparam int LW        = $clog2(MAX_CHARS + 1);

   localparam logic [1:0] RADIX_BIN = 2'd0;
   localparam logic [1:0] RADIX_OCT = 2'd1;
   localparam logic [1:0] RADIX_DEC = 2'd2;
   localparam logic [1:0] RADIX_HEX = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_EMIT    = 2'd2
   } state_t;

   // Map a digit value 0..15 onto '0'..'9' and lowercase 'a'..'f'.
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      logic [7:0] c;
      if (d < 4'd10) begin
         c = 8'h30 + {4'h0, d};
      end else begin
         c = 8'h57 + {4'h0, d};
      end
      return c;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        radix_q, radix_d;
   logic              neg_q, neg_d;
   logic              sign_phase_q, sign_phase_d;
   logic [WIDTH-1:0]  mag_q, mag_d;
   logic [LW-1:0]     sp_q, sp_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_char_q, out_char_d;
   logic              out_last_q, out_last_d;
   logic [LW-1:0]     out_len_q, out_len_d;

   logic [7:0]        stack_q [MAX_CHARS];

   logic [WIDTH-1:0]  dec_quot_s;
   logic [WIDTH-1:0]  dec_rem_s;
   logic [WIDTH-1:0]  mag_next_s;
   logic [3:0]        digit_s;
   logic              push_en_s;
   logic [7:0]        push_char_s;
   logic              go_emit_s;

   // Digit extraction for the current magnitude, selected by the latched radix.
   always_comb begin
      dec_quot_s = mag_q / WIDTH'(4'd10);
      dec_rem_s  = mag_q - (dec_quot_s * WIDTH'(4'd10));
      mag_next_s = mag_q;
      digit_s    = 4'h0;
      case (radix_q)
         RADIX_BIN: begin
            digit_s    = 4'(mag_q & WIDTH'(1'b1));
            mag_next_s = mag_q >> 1;
         end
         RADIX_OCT: begin
            digit_s    = 4'(mag_q & WIDTH'(3'd7));
            mag_next_s = mag_q >> 3;
         end
         RADIX_DEC: begin
            digit_s    = 4'(dec_rem_s);
            mag_next_s = dec_quot_s;
         end
         RADIX_HEX: begin
            digit_s    = 4'(mag_q & WIDTH'(4'd15));
            mag_next_s = mag_q >> 4;
         end
         default: begin
            digit_s    = 4'h0;
            mag_next_s = {WIDTH{1'b0}};
         end
      endcase
   end

   // Next-state and output logic for the IDLE / CONVERT / EMIT sequence.
   always_comb begin
      state_d      = state_q;
      radix_d      = radix_q;
      neg_d        = neg_q;
      sign_phase_d = sign_phase_q;
      mag_d        = mag_q;
      sp_d         = sp_q;
      in_ready_d   = in_ready_q;
      busy_d       = busy_q;
      out_valid_d  = out_valid_q;
      out_char_d   = out_char_q;
      out_last_d   = out_last_q;
      out_len_d    = out_len_q;
      push_en_s    = 1'b0;
      push_char_s  = digit_to_ascii(digit_s);
      go_emit_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               // Only decimal honours signedness. The negation is taken modulo
               // 2^WIDTH, so the most negative value stays representable.
               state_d      = ST_CONVERT;
               radix_d      = in_radix;
               neg_d        = in_signed && (in_radix == RADIX_DEC) && in_value[WIDTH-1];
               mag_d        = (in_signed && (in_radix == RADIX_DEC) && in_value[WIDTH-1])
                              ? (~in_value + WIDTH'(1'b1)) : in_value;
               sign_phase_d = 1'b0;
               sp_d         = {LW{1'b0}};
               in_ready_d   = 1'b0;
               busy_d       = 1'b1;
            end else begin
               in_ready_d   = 1'b1;
               busy_d       = 1'b0;
            end
         end

         ST_CONVERT: begin
            push_en_s = 1'b1;
            if (sign_phase_q) begin
               push_char_s = 8'h2d;
               go_emit_s   = 1'b1;
            end else begin
               push_char_s = digit_to_ascii(digit_s);
               mag_d       = mag_next_s;
               if (mag_next_s == {WIDTH{1'b0}}) begin
                  if (neg_q) begin
                     sign_phase_d = 1'b1;
                     sp_d         = sp_q + LW'(1'b1);
                  end else begin
                     go_emit_s    = 1'b1;
                  end
               end else begin
                  sp_d = sp_q + LW'(1'b1);
               end
            end
            // The character pushed now is the first one out. It is presented
            // directly, and sp stays at the count of characters still stacked.
            if (go_emit_s) begin
               state_d      = ST_EMIT;
               out_valid_d  = 1'b1;
               out_char_d   = push_char_s;
               out_last_d   = (sp_q == {LW{1'b0}});
               out_len_d    = sp_q + LW'(1'b1);
               sign_phase_d = 1'b0;
            end else begin
               out_valid_d  = 1'b0;
            end
         end

         ST_EMIT: begin
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  in_ready_d  = 1'b1;
                  busy_d      = 1'b0;
               end else begin
                  out_char_d  = stack_q[sp_q - LW'(1'b1)];
                  sp_d        = sp_q - LW'(1'b1);
                  out_last_d  = (sp_q == LW'(1'b1));
               end
            end else begin
               out_valid_d = out_valid_q;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and registered outputs. Reset discards any string in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         radix_q      <= RADIX_BIN;
         neg_q        <= 1'b0;
         sign_phase_q <= 1'b0;
         mag_q        <= {WIDTH{1'b0}};
         sp_q         <= {LW{1'b0}};
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_char_q   <= 8'h00;
         out_last_q   <= 1'b0;
         out_len_q    <= {LW{1'b0}};
      end else begin
         state_q      <= state_d;
         radix_q      <= radix_d;
         neg_q        <= neg_d;
         sign_phase_q <= sign_phase_d;
         mag_q        <= mag_d;
         sp_q         <= sp_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         out_char_q   <= out_char_d;
         out_last_q   <= out_last_d;
         out_len_q    <= out_len_d;
      end
   end

   // Character stack: written at the current depth while digits are produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_CHARS; i++) begin
            stack_q[i] <= 8'h00;
         end
      end else if (push_en_s) begin
         stack_q[sp_q] <= push_char_s;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign out_last  = out_last_q;
   assign out_len   = out_len_q;

endmodule

// File: tb/tb_num_to_ascii_stream.sv
// Directed bench for num_to_ascii_stream (WIDTH=32). Each request is checked
// for the number of conversion cycles, every streamed character, the out_last
// and out_len values, and the handshake state once the string has ended.
module tb_num_to_ascii_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [1:0]  in_radix;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_char;
   logic        out_last;
   logic [5:0]  out_len;
   logic        busy;

   int checks_q;
   int errors_q;

   num_to_ascii_stream #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .in_radix  (in_radix),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .out_last  (out_last),
      .out_len   (out_len),
      .busy      (busy)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_q++;
      if (got !== exp) begin
         errors_q++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request and follow its string. When abort_after is greater than 0,
   // return after that many characters have been handshaked. When hold_next is set,
   // in_valid stays high with a different request (hex 0xA) for the whole run.
   task automatic conv(input string tag, input logic [31:0] v, input logic [1:0] r,
                       input logic s, input string exp, input bit stall,
                       input bit hold_next, input int abort_after);
      int  cyc;
      int  idx;
      int  guard;
      bit  done;
      in_value  = v;
      in_radix  = r;
      in_signed = s;
      in_valid  = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (hold_next) begin
         in_value  = 32'h0000_000A;
         in_radix  = 2'd3;
         in_signed = 1'b0;
      end else begin
         in_valid  = 1'b0;
         in_value  = 32'h5555_5555;
         in_radix  = 2'd0;
      end
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq({tag, "_cycles"}, 64'(cyc), 64'(exp.len()));
      idx = 0;
      guard = 0;
      done = 1'b0;
      while (!done && guard < 400) begin
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
         check_eq({tag, "_chr"}, 64'(out_char), 64'(exp[idx]));
         check_eq({tag, "_last"}, 64'(out_last), 64'(idx == exp.len() - 1));
         check_eq({tag, "_len"}, 64'(out_len), 64'(exp.len()));
         check_eq({tag, "_inrdy_busy"}, 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            idx++;
            if (idx >= exp.len() || idx == abort_after) begin
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
         guard++;
      end
      check_eq({tag, "_timeout"}, 64'(done), 64'd1);
      if (abort_after <= 0) begin
         check_eq({tag, "_end_valid"}, 64'(out_valid), 64'd0);
         check_eq({tag, "_end_ready"}, 64'(in_ready), 64'd1);
      end
      out_ready = 1'b1;
   endtask

   // Directed sequence.
   initial begin
      checks_q  = 0;
      errors_q  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_value  = 32'h0;
      in_radix  = 2'd0;
      in_signed = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_last", 64'(out_last), 64'd0);
      check_eq("rst_out_char", 64'(out_char), 64'd0);
      check_eq("rst_out_len", 64'(out_len), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      conv("hex_deadbeef", 32'hDEADBEEF, 2'd3, 1'b0, "deadbeef", 1'b0, 1'b0, 0);
      conv("dec_s_m123", 32'hFFFFFF85, 2'd2, 1'b1, "-123", 1'b0, 1'b0, 0);
      conv("dec_u_m123", 32'hFFFFFF85, 2'd2, 1'b0, "4294967173", 1'b0, 1'b0, 0);
      conv("dec_s_min", 32'h8000_0000, 2'd2, 1'b1, "-2147483648", 1'b0, 1'b0, 0);
      conv("dec_u_max", 32'hFFFFFFFF, 2'd2, 1'b0, "4294967295", 1'b0, 1'b0, 0);
      conv("bin_zero", 32'h0, 2'd0, 1'b0, "0", 1'b0, 1'b0, 0);
      conv("oct_17", 32'o17, 2'd1, 1'b0, "17", 1'b0, 1'b0, 0);
      conv("bin_5", 32'd5, 2'd0, 1'b0, "101", 1'b0, 1'b0, 0);
      conv("hex_signed_ign", 32'hFFFFFF85, 2'd3, 1'b1, "ffffff85", 1'b0, 1'b0, 0);
      conv("dec_zero_s", 32'h0, 2'd2, 1'b1, "0", 1'b0, 1'b0, 0);

      // Stalled sink with the next request already waiting on the input.
      conv("stall_deadbeef", 32'hDEADBEEF, 2'd3, 1'b0, "deadbeef", 1'b1, 1'b1, 0);
      conv("held_a", 32'h0000_000A, 2'd3, 1'b0, "a", 1'b0, 1'b0, 0);

      // Reset while the string is being emitted, three characters in.
      conv("rst_mid", 32'hFFFFFFFF, 2'd2, 1'b0, "4294967295", 1'b0, 1'b0, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
      check_eq("rst_mid_last", 64'(out_last), 64'd0);
      check_eq("rst_mid_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_valid", 64'(out_valid), 64'd0);
      check_eq("post_rst_ready", 64'(in_ready), 64'd1);
      conv("post_rst_a", 32'h0000_000A, 2'd3, 1'b0, "a", 1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
      $finish;
   end

endmodule
